// File: rtl/rx_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// rx_ctrl_fsm_pkg -- shared UART receive definitions
//
// Purpose : holds the receive-controller state encoding, the number of data
//           bits per frame and the check-tick offset. The check tick is the
//           oversample index that follows the three middle samples of a bit.
//           Those samples are prescale/2-1, prescale/2 and prescale/2+1, so
//           the tick is prescale/2 + CHECK_OFFSET.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package rx_ctrl_fsm_pkg;

  // Receive controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Payload bits per frame. Data bits occupy bit_cnt 1..DATA_BITS.
  localparam int unsigned DATA_BITS     = 8;
  localparam logic [3:0]  LAST_DATA_BIT = 4'(DATA_BITS);

  // Distance of the check tick from the bit midpoint
  localparam logic [5:0]  CHECK_OFFSET  = 6'd2;

  // Prescale value held after reset, before the first IDLE latch
  localparam logic [5:0]  PRESCALE_RST  = 6'd8;

  // Oversample index at which checker results are valid within a bit
  function automatic logic [5:0] check_tick(input logic [5:0] prescale);
    return {1'b0, prescale[5:1]} + CHECK_OFFSET;
  endfunction

endpackage : rx_ctrl_fsm_pkg

// File: rtl/rx_ctrl_fsm_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter -- oversample tick / bit index counter
//
// Purpose : counts edge_cnt from 0 to prescale-1 while enabled. On the wrap
//           it increments bit_cnt. When disabled, the counter holds both
//           values at 0. The clear input returns both values to 0 on the next
//           edge, so a frame can end and a new frame can start directly with
//           bit 0.
// Ports   : clk      - clock, rising edge
//           rst_n    - asynchronous active-low reset
//           enable   - count while high, hold zero while low
//           clear    - synchronous return to edge 0 / bit 0
//           prescale - oversampling ratio (8, 16 or 32)
//           edge_cnt - oversample index within the current bit
//           bit_cnt  - bit index within the frame
// -----------------------------------------------------------------------------
module edge_bit_counter
  import rx_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [5:0] prescale,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt
);

  logic [5:0] edge_cnt_r;
  logic [3:0] bit_cnt_r;
  logic       last_edge_s;

  assign last_edge_s = (edge_cnt_r == (prescale - 6'd1));

  // Edge and bit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r <= 6'd0;
      bit_cnt_r  <= 4'd0;
    end else if (!enable || clear) begin
      edge_cnt_r <= 6'd0;
      bit_cnt_r  <= 4'd0;
    end else if (last_edge_s) begin
      edge_cnt_r <= 6'd0;
      bit_cnt_r  <= bit_cnt_r + 4'd1;
    end else begin
      edge_cnt_r <= edge_cnt_r + 6'd1;
      bit_cnt_r  <= bit_cnt_r;
    end
  end

  assign edge_cnt = edge_cnt_r;
  assign bit_cnt  = bit_cnt_r;

endmodule : edge_bit_counter

// File: rtl/rx_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// rx_ctrl_fsm -- UART receive frame controller
//
// Purpose : sequences one UART frame (start, 8 data bits, optional parity,
//           stop) from oversample ticks. At the check tick of each bit it
//           strobes the matching checker or the deserializer. It registers
//           the checker results and reports a good frame with data_valid.
//           All outputs are registered. Each strobe is set one tick early, so
//           it is high in the cycle where edge_cnt equals its tick.
// Ports   : clk, rst_n    - clock (rising edge), asynchronous active-low reset
//           rx_in         - serial line, idle high
//           prescale      - oversampling ratio 8/16/32, latched in IDLE
//           par_en        - parity bit present, latched in IDLE
//           start_glitch  - start checker result (1 = start bit sampled high)
//           par_err       - parity checker result (1 = mismatch)
//           stop_err      - stop checker result (1 = stop bit sampled low)
//           dat_samp_en   - data sampler enable, high outside IDLE
//           deser_en      - one-cycle shift strobe per data bit
//           start_chk_en, par_chk_en, stop_chk_en - one-cycle checker enables
//           edge_cnt      - oversample index within the current bit
//           bit_cnt       - bit index within the frame
//           data_valid    - one-cycle pulse at the end of a good frame
//           frame_err     - stop error of the current/last frame
//           parity_err    - parity error of the current/last frame
// -----------------------------------------------------------------------------
module rx_ctrl_fsm
  import rx_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       start_glitch,
  input  logic       par_err,
  input  logic       stop_err,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       start_chk_en,
  output logic       par_chk_en,
  output logic       stop_chk_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err
);

  rx_state_e  state_r;
  logic [5:0] prescale_r;
  logic       par_en_r;
  logic       glitch_r;
  logic       dat_samp_en_r;
  logic       deser_en_r;
  logic       start_chk_en_r;
  logic       par_chk_en_r;
  logic       stop_chk_en_r;
  logic       data_valid_r;
  logic       frame_err_r;
  logic       parity_err_r;

  logic [5:0] edge_cnt_s;
  logic [3:0] bit_cnt_s;
  logic [5:0] tick_s;
  logic       pre_tick_s;
  logic       at_tick_s;
  logic       pre_last_s;
  logic       last_edge_s;
  logic       cnt_enable_s;
  logic       cnt_clear_s;
  logic       frame_err_nxt_s;

  // Strobes are registered, so they are set one edge before their tick
  assign tick_s      = check_tick(prescale_r);
  assign pre_tick_s  = (edge_cnt_s == (tick_s - 6'd1));
  assign at_tick_s   = (edge_cnt_s == tick_s);
  assign pre_last_s  = (edge_cnt_s == (prescale_r - 6'd2));
  assign last_edge_s = (edge_cnt_s == (prescale_r - 6'd1));

  // For prescale 8 the stop check tick and the data_valid decision fall on
  // the same edge. The decision therefore uses the value frame_err is about
  // to take, not the stale registered value.
  assign frame_err_nxt_s = at_tick_s ? stop_err : frame_err_r;

  // The counter runs in every non-IDLE state. It is cleared when the frame
  // ends (stop bit done or start glitch), so the next state, IDLE or a
  // back-to-back START, begins at edge 0 / bit 0.
  assign cnt_enable_s = (state_r != ST_IDLE);
  assign cnt_clear_s  = last_edge_s &&
                        ((state_r == ST_STOP) ||
                         ((state_r == ST_START) && glitch_r));

  edge_bit_counter u_edge_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (cnt_enable_s),
    .clear    (cnt_clear_s),
    .prescale (prescale_r),
    .edge_cnt (edge_cnt_s),
    .bit_cnt  (bit_cnt_s)
  );

  // Frame sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      prescale_r     <= PRESCALE_RST;
      par_en_r       <= 1'b0;
      glitch_r       <= 1'b0;
      dat_samp_en_r  <= 1'b0;
      deser_en_r     <= 1'b0;
      start_chk_en_r <= 1'b0;
      par_chk_en_r   <= 1'b0;
      stop_chk_en_r  <= 1'b0;
      data_valid_r   <= 1'b0;
      frame_err_r    <= 1'b0;
      parity_err_r   <= 1'b0;
    end else begin
      // Strobes last one cycle unless re-armed below
      deser_en_r     <= 1'b0;
      start_chk_en_r <= 1'b0;
      par_chk_en_r   <= 1'b0;
      stop_chk_en_r  <= 1'b0;
      data_valid_r   <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // Frame configuration is only taken while idle
          prescale_r <= prescale;
          par_en_r   <= par_en;
          if (!rx_in) begin
            state_r       <= ST_START;
            dat_samp_en_r <= 1'b1;
            glitch_r      <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
          end else begin
            state_r       <= ST_IDLE;
            dat_samp_en_r <= 1'b0;
          end
        end

        ST_START: begin
          if (pre_tick_s) begin
            start_chk_en_r <= 1'b1;
          end else begin
            start_chk_en_r <= 1'b0;
          end
          if (at_tick_s) begin
            glitch_r <= start_glitch;
          end else begin
            glitch_r <= glitch_r;
          end
          // A false start is dropped only after the whole start bit
          if (last_edge_s) begin
            if (glitch_r) begin
              state_r       <= ST_IDLE;
              dat_samp_en_r <= 1'b0;
            end else begin
              state_r       <= ST_DATA;
            end
          end else begin
            state_r <= ST_START;
          end
        end

        ST_DATA: begin
          if (pre_tick_s) begin
            deser_en_r <= 1'b1;
          end else begin
            deser_en_r <= 1'b0;
          end
          if (last_edge_s && (bit_cnt_s == LAST_DATA_BIT)) begin
            state_r <= par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            state_r <= ST_DATA;
          end
        end

        ST_PARITY: begin
          if (pre_tick_s) begin
            par_chk_en_r <= 1'b1;
          end else begin
            par_chk_en_r <= 1'b0;
          end
          if (at_tick_s) begin
            parity_err_r <= par_err;
          end else begin
            parity_err_r <= parity_err_r;
          end
          if (last_edge_s) begin
            state_r <= ST_STOP;
          end else begin
            state_r <= ST_PARITY;
          end
        end

        ST_STOP: begin
          if (pre_tick_s) begin
            stop_chk_en_r <= 1'b1;
          end else begin
            stop_chk_en_r <= 1'b0;
          end
          if (at_tick_s) begin
            frame_err_r <= stop_err;
          end else begin
            frame_err_r <= frame_err_r;
          end
          // data_valid is high in the last oversample cycle of the stop bit
          if (pre_last_s) begin
            data_valid_r <= !frame_err_nxt_s && !parity_err_r;
          end else begin
            data_valid_r <= 1'b0;
          end
          if (last_edge_s) begin
            if (!rx_in) begin
              // Back-to-back frame: the line is already in the next start bit
              state_r       <= ST_START;
              dat_samp_en_r <= 1'b1;
              glitch_r      <= 1'b0;
              frame_err_r   <= 1'b0;
              parity_err_r  <= 1'b0;
            end else begin
              state_r       <= ST_IDLE;
              dat_samp_en_r <= 1'b0;
            end
          end else begin
            state_r <= ST_STOP;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          dat_samp_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign dat_samp_en  = dat_samp_en_r;
  assign deser_en     = deser_en_r;
  assign start_chk_en = start_chk_en_r;
  assign par_chk_en   = par_chk_en_r;
  assign stop_chk_en  = stop_chk_en_r;
  assign edge_cnt     = edge_cnt_s;
  assign bit_cnt      = bit_cnt_s;
  assign data_valid   = data_valid_r;
  assign frame_err    = frame_err_r;
  assign parity_err   = parity_err_r;

endmodule : rx_ctrl_fsm

// File: tb/tb_rx_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_rx_ctrl_fsm -- directed self-checking bench for rx_ctrl_fsm
//
// Cycle k of a frame is the cycle after the k-th rising edge. Edge 0 is the
// edge that sees rx_in low in IDLE. Outputs are sampled 1 time unit after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_rx_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       start_glitch;
  logic       par_err;
  logic       stop_err;
  logic       dat_samp_en;
  logic       deser_en;
  logic       start_chk_en;
  logic       par_chk_en;
  logic       stop_chk_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame monitor results, filled by run_frame
  int m_deser, m_schk, m_pchk, m_tchk, m_dv;
  int m_dv_k, m_dv_abs, m_first_deser, m_schk_k, m_pchk_k, m_tchk_k;
  int m_cnt_bad, m_excl_bad, m_samp_off, m_flags_k0, m_rst_nz;

  always #5 clk = ~clk;

  rx_ctrl_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .par_en       (par_en),
    .start_glitch (start_glitch),
    .par_err      (par_err),
    .stop_err     (stop_err),
    .dat_samp_en  (dat_samp_en),
    .deser_en     (deser_en),
    .start_chk_en (start_chk_en),
    .par_chk_en   (par_chk_en),
    .stop_chk_en  (stop_chk_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  function automatic int out_sum();
    return int'(dat_samp_en) + int'(deser_en) + int'(start_chk_en) + int'(par_chk_en) +
           int'(stop_chk_en) + int'(data_valid) + int'(frame_err) + int'(parity_err) +
           int'(edge_cnt) + int'(bit_cnt);
  endfunction

  // Drives one frame starting from IDLE (or from a back-to-back STOP) and
  // records what the DUT does. Optionally pulses rst_n at cycle rst_at.
  task automatic run_frame(input int p, input bit pe, input logic [7:0] data,
                           input bit b2b, input int rst_at);
    int nbits, tot_c, b;
    m_deser = 0; m_schk = 0; m_pchk = 0; m_tchk = 0; m_dv = 0;
    m_dv_k = -1; m_dv_abs = -1; m_first_deser = -1; m_schk_k = -1; m_pchk_k = -1; m_tchk_k = -1;
    m_cnt_bad = 0; m_excl_bad = 0; m_samp_off = 0; m_flags_k0 = -1; m_rst_nz = -1;
    nbits = pe ? 11 : 10;
    tot_c = nbits * p;
    prescale = 6'(p);
    par_en = pe;
    rx_in = 1'b0;
    for (int k = 0; k < tot_c; k++) begin
      step();
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        m_rst_nz = out_sum();
        step();
        step();
        rx_in = 1'b1;
        rst_n = 1'b1;
        step();
        break;
      end
      if (k == 0) m_flags_k0 = int'(frame_err) + int'(parity_err);
      if (edge_cnt != 6'(k % p) || bit_cnt != 4'(k / p)) m_cnt_bad++;
      if (deser_en) begin m_deser++; if (m_first_deser < 0) m_first_deser = k; end
      if (start_chk_en) begin m_schk++; m_schk_k = k; end
      if (par_chk_en) begin m_pchk++; m_pchk_k = k; end
      if (stop_chk_en) begin m_tchk++; m_tchk_k = k; end
      if (int'(deser_en) + int'(start_chk_en) + int'(par_chk_en) + int'(stop_chk_en) > 1) m_excl_bad++;
      if (!dat_samp_en) m_samp_off++;
      if (data_valid) begin m_dv++; if (m_dv_k < 0) begin m_dv_k = k; m_dv_abs = cyc; end end
      b = (k + 1) / p;
      if (b == 0) rx_in = 1'b0;
      else if (b <= 8) rx_in = data[b-1];
      else if (pe && b == 9) rx_in = ^data;
      else rx_in = 1'b1;
      if (b2b && (k + 1 == tot_c - 1)) rx_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    start_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
    #3;
    total++; if (out_sum() !== 0) begin bad++; $display("FAIL reset_outputs got_sum=%0d exp=0", out_sum()); end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    total++; if (dat_samp_en !== 1'b0) begin bad++; $display("FAIL idle_samp got=%b exp=0", dat_samp_en); end
    total++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin bad++; $display("FAIL idle_cnt got=%0d/%0d exp=0/0", edge_cnt, bit_cnt); end
  endtask

  task automatic test_good_frame();
    run_frame(8, 1'b0, 8'h55, 1'b0, -1);
    total++; if (m_deser !== 8) begin bad++; $display("FAIL good_deser got=%0d exp=8", m_deser); end
    total++; if (m_first_deser !== 14) begin bad++; $display("FAIL good_first_deser got=%0d exp=14", m_first_deser); end
    total++; if (m_schk !== 1 || m_schk_k !== 6) begin bad++; $display("FAIL good_start_chk got=%0d@%0d exp=1@6", m_schk, m_schk_k); end
    total++; if (m_tchk !== 1 || m_tchk_k !== 78) begin bad++; $display("FAIL good_stop_chk got=%0d@%0d exp=1@78", m_tchk, m_tchk_k); end
    total++; if (m_pchk !== 0) begin bad++; $display("FAIL good_par_chk got=%0d exp=0", m_pchk); end
    total++; if (m_dv !== 1 || m_dv_k !== 79) begin bad++; $display("FAIL good_dv got=%0d@%0d exp=1@79", m_dv, m_dv_k); end
    total++; if (m_cnt_bad !== 0) begin bad++; $display("FAIL good_counters got=%0d exp=0", m_cnt_bad); end
    total++; if (m_excl_bad !== 0 || m_samp_off !== 0) begin bad++; $display("FAIL good_strobes got=%0d/%0d exp=0/0", m_excl_bad, m_samp_off); end
    total++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL good_flags got=%b%b exp=00", frame_err, parity_err); end
    step();
    total++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL good_back_idle got samp=%b edge=%0d bit=%0d dv=%b exp 0/0/0/0", dat_samp_en, edge_cnt, bit_cnt, data_valid); end
  endtask

  task automatic test_parity_error();
    par_err = 1'b1;
    run_frame(16, 1'b1, 8'hA3, 1'b0, -1);
    total++; if (m_deser !== 8) begin bad++; $display("FAIL par_deser got=%0d exp=8", m_deser); end
    total++; if (m_pchk !== 1 || m_pchk_k !== 154) begin bad++; $display("FAIL par_chk got=%0d@%0d exp=1@154", m_pchk, m_pchk_k); end
    total++; if (m_tchk_k !== 170) begin bad++; $display("FAIL par_stop_chk got=%0d exp=170", m_tchk_k); end
    total++; if (m_dv !== 0) begin bad++; $display("FAIL par_no_dv got=%0d exp=0", m_dv); end
    total++; if (m_cnt_bad !== 0) begin bad++; $display("FAIL par_counters got=%0d exp=0", m_cnt_bad); end
    total++; if (parity_err !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL par_flags got=%b%b exp=10", parity_err, frame_err); end
    step();
    total++; if (dat_samp_en !== 1'b0 || parity_err !== 1'b1) begin bad++; $display("FAIL par_idle_hold got samp=%b perr=%b exp 0/1", dat_samp_en, parity_err); end
    par_err = 1'b0;
  endtask

  task automatic test_stop_error();
    stop_err = 1'b1;
    run_frame(8, 1'b0, 8'h0F, 1'b0, -1);
    total++; if (m_dv !== 0) begin bad++; $display("FAIL stop_no_dv got=%0d exp=0", m_dv); end
    total++; if (frame_err !== 1'b1 || parity_err !== 1'b0) begin bad++; $display("FAIL stop_flags got=%b%b exp=10", frame_err, parity_err); end
    step();
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL stop_hold got=%b exp=1", frame_err); end
    stop_err = 1'b0;
    run_frame(8, 1'b0, 8'hF0, 1'b0, -1);
    total++; if (m_flags_k0 !== 0) begin bad++; $display("FAIL stop_clear_at_start got=%0d exp=0", m_flags_k0); end
    total++; if (m_dv !== 1 || m_dv_k !== 79 || frame_err !== 1'b0) begin bad++; $display("FAIL stop_next_frame got dv=%0d@%0d ferr=%b exp 1@79 0", m_dv, m_dv_k, frame_err); end
    step();
  endtask

  task automatic test_start_glitch();
    int n_schk = 0, schk_k = -1, n_deser = 0, n_on = 0, n_after = 0;
    prescale = 6'd8; par_en = 1'b0; start_glitch = 1'b1;
    rx_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (start_chk_en) begin n_schk++; schk_k = k; end
      if (deser_en) n_deser++;
      if (dat_samp_en) n_on++;
      rx_in = 1'b1;
    end
    total++; if (n_schk !== 1 || schk_k !== 6) begin bad++; $display("FAIL glitch_start_chk got=%0d@%0d exp=1@6", n_schk, schk_k); end
    total++; if (n_on !== 8 || n_deser !== 0) begin bad++; $display("FAIL glitch_frame got samp=%0d deser=%0d exp 8/0", n_on, n_deser); end
    step();
    total++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
      bad++; $display("FAIL glitch_idle got samp=%b edge=%0d bit=%0d exp 0/0/0", dat_samp_en, edge_cnt, bit_cnt); end
    for (int k = 0; k < 16; k++) begin
      step();
      n_after += int'(deser_en) + int'(data_valid) + int'(start_chk_en) + int'(stop_chk_en) + int'(par_chk_en);
    end
    total++; if (n_after !== 0) begin bad++; $display("FAIL glitch_quiet got=%0d exp=0", n_after); end
    start_glitch = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dv1;
    run_frame(32, 1'b1, 8'h3C, 1'b1, -1);
    dv1 = m_dv_abs;
    total++; if (m_dv !== 1 || m_dv_k !== 351) begin bad++; $display("FAIL b2b_dv1 got=%0d@%0d exp=1@351", m_dv, m_dv_k); end
    run_frame(32, 1'b1, 8'hC3, 1'b0, -1);
    total++; if (m_samp_off !== 0 || m_cnt_bad !== 0) begin bad++; $display("FAIL b2b_direct_start got off=%0d cnt=%0d exp 0/0", m_samp_off, m_cnt_bad); end
    total++; if (m_dv !== 1 || (m_dv_abs - dv1) !== 352) begin bad++; $display("FAIL b2b_gap got=%0d exp=352", m_dv_abs - dv1); end
    total++; if (m_deser !== 8) begin bad++; $display("FAIL b2b_deser got=%0d exp=8", m_deser); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    int n_dv = 0;
    run_frame(8, 1'b0, 8'h5A, 1'b0, 35);
    total++; if (m_rst_nz !== 0) begin bad++; $display("FAIL midrst_outputs got_sum=%0d exp=0", m_rst_nz); end
    total++; if (m_deser !== 3 || m_dv !== 0) begin bad++; $display("FAIL midrst_partial got deser=%0d dv=%0d exp 3/0", m_deser, m_dv); end
    for (int k = 0; k < 10; k++) begin
      step();
      n_dv += int'(data_valid) + int'(dat_samp_en);
    end
    total++; if (n_dv !== 0) begin bad++; $display("FAIL midrst_idle got=%0d exp=0", n_dv); end
    run_frame(8, 1'b0, 8'hA5, 1'b0, -1);
    total++; if (m_dv !== 1 || m_dv_k !== 79 || m_deser !== 8 || m_cnt_bad !== 0) begin
      bad++; $display("FAIL midrst_next got dv=%0d@%0d deser=%0d cnt=%0d exp 1@79 8 0", m_dv, m_dv_k, m_deser, m_cnt_bad); end
    step();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx_ctrl_fsm
